// File: rtl/riscv_fetch_pkg.sv
// Shared types and defaults for the instruction prefetch buffer.
// Fetch entries pair an instruction word with the PC it was fetched from.
package riscv_fetch_pkg;

    localparam int FETCH_DEPTH  = 4;
    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// Small synchronous FIFO of fetch entries with push, pop and flush.
// Flush wins over push/pop; push into a full FIFO is accepted only alongside a pop.
module riscv_fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter  int DEPTH = FETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  fetch_entry_t       pushEntry,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       headEntry,
    output logic               full,
    output logic               empty,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t     memArray [DEPTH];
    logic [PTR_W-1:0] wrPtrReg;
    logic [PTR_W-1:0] rdPtrReg;
    logic [CNT_W-1:0] countReg;
    logic             doPush;
    logic             doPop;

    assign full  = (countReg == CNT_W'(DEPTH));
    assign empty = (countReg == '0);
    assign count = countReg;

    assign doPush = push && (!full || pop);
    assign doPop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else if (flush) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            countReg <= countReg + CNT_W'(doPush) - CNT_W'(doPop);
        end
    end

    // Storage carries no reset; the head is masked while empty instead.
    always_ff @(posedge clk) begin
        if (doPush && !flush) begin
            memArray[wrPtrReg] <= pushEntry;
        end
    end

    assign headEntry = empty ? '0 : memArray[rdPtrReg];

endmodule

// File: rtl/riscv_fetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches, queues responses
// with their PCs, and flushes on redirect while discarding in-flight old-stream data.
module riscv_fetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] i_boot_addr,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    input  logic              i_stall,
    output logic              o_instr_valid,
    output logic [DATA_W-1:0] o_instr,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_req,
    output logic [ADDR_W-1:0] o_addr,
    input  logic              i_gnt,
    input  logic              i_rvalid,
    input  logic [DATA_W-1:0] i_rdata
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

    fetch_state_e     stateReg, stateNext;
    logic [ADDR_W-1:0] fetchPcReg, fetchPcNext;
    logic [ADDR_W-1:0] respPcReg, respPcNext;
    logic [ADDR_W-1:0] staleAddrReg, staleAddrNext;
    logic [CNT_W-1:0]  outstandingReg, outstandingNext;
    logic [CNT_W-1:0]  discardReg, discardNext;
    logic              reqPendingReg, reqPendingNext;
    logic              staleReg, staleNext;

    logic              reqOut;
    logic              reqAccept;
    logic [CNT_W:0]    creditSum;
    logic              fifoPush, fifoPop, fifoFlush;
    logic              fifoFull, fifoEmpty;
    logic [CNT_W-1:0]  fifoCount;
    fetch_entry_t      pushEntry, headEntry;
    logic [ADDR_W-1:0] bootAligned, redirAligned;

    assign bootAligned  = i_boot_addr & ALIGN_MASK;
    assign redirAligned = i_redirect_pc & ALIGN_MASK;
    assign creditSum    = {1'b0, fifoCount} + {1'b0, outstandingReg};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg       <= BOOT;
            fetchPcReg     <= '0;
            respPcReg      <= '0;
            staleAddrReg   <= '0;
            outstandingReg <= '0;
            discardReg     <= '0;
            reqPendingReg  <= 1'b0;
            staleReg       <= 1'b0;
        end else begin
            stateReg       <= stateNext;
            fetchPcReg     <= fetchPcNext;
            respPcReg      <= respPcNext;
            staleAddrReg   <= staleAddrNext;
            outstandingReg <= outstandingNext;
            discardReg     <= discardNext;
            reqPendingReg  <= reqPendingNext;
            staleReg       <= staleNext;
        end
    end

    always_comb begin
        stateNext       = stateReg;
        fetchPcNext     = fetchPcReg;
        respPcNext      = respPcReg;
        staleAddrNext   = staleAddrReg;
        outstandingNext = outstandingReg;
        discardNext     = discardReg;
        reqPendingNext  = reqPendingReg;
        staleNext       = staleReg;
        reqOut          = 1'b0;
        reqAccept       = 1'b0;
        fifoPush        = 1'b0;
        fifoPop         = 1'b0;
        fifoFlush       = 1'b0;

        case (stateReg)
            BOOT: begin
                stateNext   = RUN;
                fetchPcNext = bootAligned;
                respPcNext  = bootAligned;
            end
            RUN: begin
                // Credit covers buffered plus in-flight words so responses never stall.
                reqOut          = reqPendingReg || (creditSum < (CNT_W + 1)'(DEPTH));
                reqAccept       = reqOut && i_gnt;
                reqPendingNext  = reqOut && !i_gnt;
                outstandingNext = outstandingReg + CNT_W'(reqAccept) - CNT_W'(i_rvalid);

                // A stale request was issued before a redirect; its grant must not
                // advance the new-stream fetch address.
                if (reqAccept) begin
                    if (staleReg) begin
                        staleNext = 1'b0;
                    end else begin
                        fetchPcNext = fetchPcReg + WORD_STEP;
                    end
                end

                if (i_redirect) begin
                    fifoFlush   = 1'b1;
                    fetchPcNext = redirAligned;
                    respPcNext  = redirAligned;
                    discardNext = outstandingNext + CNT_W'(reqPendingNext);
                    if (reqPendingNext && !staleReg) begin
                        staleNext     = 1'b1;
                        staleAddrNext = fetchPcReg;
                    end
                end else begin
                    fifoPop = !fifoEmpty && !i_stall;
                    if (i_rvalid) begin
                        if (discardReg != '0) begin
                            discardNext = discardReg - CNT_W'(1);
                        end else begin
                            fifoPush   = !fifoFull || fifoPop;
                            respPcNext = respPcReg + WORD_STEP;
                        end
                    end
                end
            end
            default: stateNext = BOOT;
        endcase
    end

    assign pushEntry = '{pc: respPcReg, instr: i_rdata};

    riscv_fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifoPush),
        .pushEntry (pushEntry),
        .pop       (fifoPop),
        .flush     (fifoFlush),
        .headEntry (headEntry),
        .full      (fifoFull),
        .empty     (fifoEmpty),
        .count     (fifoCount)
    );

    assign o_req         = reqOut;
    assign o_addr        = staleReg ? staleAddrReg : fetchPcReg;
    assign o_instr_valid = !fifoEmpty;
    assign o_instr       = headEntry.instr;
    assign o_pc          = headEntry.pc;

endmodule

// File: tb/tb_riscv_fetch_buffer.sv
// Directed bench for riscv_fetch_buffer: a per-cycle vector table for boot and
// redirect corners, then hand sequences for wrap, backpressure and async reset.
module tb_riscv_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] i_boot_addr;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;
    logic        i_stall;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_pc;
    logic        o_req;
    logic [31:0] o_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;

    always #5 clk = ~clk;

    riscv_fetch_buffer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_boot_addr   (i_boot_addr),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_stall       (i_stall),
        .o_instr_valid (o_instr_valid),
        .o_instr       (o_instr),
        .o_pc          (o_pc),
        .o_req         (o_req),
        .o_addr        (o_addr),
        .i_gnt         (i_gnt),
        .i_rvalid      (i_rvalid),
        .i_rdata       (i_rdata)
    );

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        stall;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rAddr;
        logic        eReq;
        logic [31:0] eAddr;
        logic        eValid;
        logic [31:0] ePc;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          grantCyc;
    } mem_req_t;

    localparam int NV = 21;

    int       total = 0;
    int       bad   = 0;
    int       cyc;
    mem_req_t memQ[$];
    vec_t     vecs[NV];

    function automatic logic [31:0] instrOf(input logic [31:0] pc);
        return {16'hC0DE, pc[15:0]};
    endfunction

    function automatic vec_t mk(input int redir, input logic [31:0] rpc, input int stall,
                                input int gnt, input int rvalid, input logic [31:0] rAddr,
                                input int eReq, input logic [31:0] eAddr, input int eValid,
                                input logic [31:0] ePc);
        vec_t v;
        v.redir  = (redir != 0);
        v.rpc    = rpc;
        v.stall  = (stall != 0);
        v.gnt    = (gnt != 0);
        v.rvalid = (rvalid != 0);
        v.rAddr  = rAddr;
        v.eReq   = (eReq != 0);
        v.eAddr  = eAddr;
        v.eValid = (eValid != 0);
        v.ePc    = ePc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic doReset(input logic [31:0] boot);
        rst_n         = 1'b0;
        i_boot_addr   = boot;
        i_redirect    = 1'b0;
        i_redirect_pc = '0;
        i_stall       = 1'b0;
        i_gnt         = 1'b0;
        i_rvalid      = 1'b0;
        i_rdata       = '0;
        memQ.delete();
        repeat (2) @(negedge clk);
        check("rst_req", {31'b0, o_req}, 32'd0);
        check("rst_addr", o_addr, 32'd0);
        check("rst_valid", {31'b0, o_instr_valid}, 32'd0);
        check("rst_instr", o_instr, 32'd0);
        check("rst_pc", o_pc, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc = -1;
    endtask

    // Memory that grants every request and answers exactly one cycle later.
    task automatic autoCycle(input logic stall);
        @(negedge clk);
        cyc++;
        i_stall    = stall;
        i_redirect = 1'b0;
        i_gnt      = 1'b1;
        if (memQ.size() > 0 && memQ[0].grantCyc < cyc) begin
            i_rvalid = 1'b1;
            i_rdata  = instrOf(memQ[0].addr);
            void'(memQ.pop_front());
        end else begin
            i_rvalid = 1'b0;
            i_rdata  = '0;
        end
        #1;
        if (o_req && i_gnt) memQ.push_back('{addr: o_addr, grantCyc: cyc});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] expPc;
        vec_t        v;

        //           redir rpc          stl gnt rv rAddr        req addr         vld pc
        vecs[0]  = mk(0, 32'h0,         0, 1, 0, 32'h0,        0, 32'h0,        0, 32'h0);
        vecs[1]  = mk(0, 32'h0,         0, 1, 0, 32'h0,        1, 32'h100,      0, 32'h0);
        vecs[2]  = mk(0, 32'h0,         0, 1, 1, 32'h100,      1, 32'h104,      0, 32'h0);
        vecs[3]  = mk(0, 32'h0,         0, 1, 1, 32'h104,      1, 32'h108,      1, 32'h100);
        vecs[4]  = mk(0, 32'h0,         0, 1, 1, 32'h108,      1, 32'h10C,      1, 32'h104);
        vecs[5]  = mk(0, 32'h0,         0, 1, 0, 32'h0,        1, 32'h110,      1, 32'h108);
        vecs[6]  = mk(1, 32'h2002,      0, 0, 0, 32'h0,        1, 32'h114,      0, 32'h0);
        vecs[7]  = mk(0, 32'h0,         0, 0, 1, 32'h10C,      1, 32'h114,      0, 32'h0);
        vecs[8]  = mk(0, 32'h0,         0, 1, 1, 32'h110,      1, 32'h114,      0, 32'h0);
        vecs[9]  = mk(0, 32'h0,         0, 1, 1, 32'h114,      1, 32'h2000,     0, 32'h0);
        vecs[10] = mk(0, 32'h0,         0, 1, 1, 32'h2000,     1, 32'h2004,     0, 32'h0);
        vecs[11] = mk(0, 32'h0,         1, 0, 1, 32'h2004,     1, 32'h2008,     1, 32'h2000);
        vecs[12] = mk(0, 32'h0,         0, 0, 0, 32'h0,        1, 32'h2008,     1, 32'h2000);
        vecs[13] = mk(1, 32'h3000,      0, 1, 0, 32'h0,        1, 32'h2008,     1, 32'h2004);
        vecs[14] = mk(0, 32'h0,         0, 1, 1, 32'h2008,     1, 32'h3000,     0, 32'h0);
        vecs[15] = mk(1, 32'h4001,      0, 0, 1, 32'h3000,     1, 32'h3004,     0, 32'h0);
        vecs[16] = mk(0, 32'h0,         0, 1, 0, 32'h0,        1, 32'h3004,     0, 32'h0);
        vecs[17] = mk(0, 32'h0,         0, 1, 1, 32'h3004,     1, 32'h4000,     0, 32'h0);
        vecs[18] = mk(0, 32'h0,         0, 0, 1, 32'h4000,     1, 32'h4004,     0, 32'h0);
        vecs[19] = mk(0, 32'h0,         0, 0, 0, 32'h0,        1, 32'h4004,     1, 32'h4000);
        vecs[20] = mk(0, 32'h0,         0, 0, 0, 32'h0,        1, 32'h4004,     0, 32'h0);

        // Table: boot, redirect with two in flight, stale pending request, redirect+gnt/rvalid.
        doReset(32'h100);
        for (int k = 0; k < NV; k++) begin
            v = vecs[k];
            @(negedge clk);
            cyc++;
            check($sformatf("v%0d_req", k), {31'b0, o_req}, {31'b0, v.eReq});
            check($sformatf("v%0d_addr", k), o_addr, v.eAddr);
            check($sformatf("v%0d_valid", k), {31'b0, o_instr_valid}, {31'b0, v.eValid});
            if (v.eValid) begin
                check($sformatf("v%0d_pc", k), o_pc, v.ePc);
                check($sformatf("v%0d_instr", k), o_instr, instrOf(v.ePc));
            end
            $display("vec %0d: req=%0b addr=%h valid=%0b pc=%h", k, o_req, o_addr, o_instr_valid, o_pc);
            i_redirect    = v.redir;
            i_redirect_pc = v.rpc;
            i_stall       = v.stall;
            i_gnt         = v.gnt;
            i_rvalid      = v.rvalid;
            i_rdata       = v.rvalid ? instrOf(v.rAddr) : 32'h0;
        end

        // Address wrap at the top of the address space.
        doReset(32'hFFFF_FFFC);
        autoCycle(1'b0);
        autoCycle(1'b0);
        check("wrap_req", {31'b0, o_req}, 32'd1);
        check("wrap_addr0", o_addr, 32'hFFFF_FFFC);
        autoCycle(1'b0);
        check("wrap_addr1", o_addr, 32'h0);
        autoCycle(1'b0);
        check("wrap_pc0", o_pc, 32'hFFFF_FFFC);
        autoCycle(1'b0);
        check("wrap_pc1", o_pc, 32'h0);
        check("wrap_instr1", o_instr, instrOf(32'h0));
        $display("wrap: pc=%h instr=%h", o_pc, o_instr);

        // Throughput, then backpressure until full, then release.
        doReset(32'h200);
        repeat (3) autoCycle(1'b0);
        expPc = 32'h200;
        for (int k = 0; k < 8; k++) begin
            autoCycle(1'b0);
            check("tp_valid", {31'b0, o_instr_valid}, 32'd1);
            check("tp_pc", o_pc, expPc);
            check("tp_instr", o_instr, instrOf(expPc));
            $display("pop pc=%h instr=%h", o_pc, o_instr);
            expPc += 32'd4;
        end
        repeat (10) autoCycle(1'b1);
        check("bp_req", {31'b0, o_req}, 32'd0);
        check("bp_valid", {31'b0, o_instr_valid}, 32'd1);
        check("bp_pc", o_pc, expPc);
        check("bp_inflight", memQ.size(), 32'd0);
        for (int k = 0; k < 12; k++) begin
            autoCycle(1'b0);
            check("rel_valid", {31'b0, o_instr_valid}, 32'd1);
            check("rel_pc", o_pc, expPc);
            check("rel_instr", o_instr, instrOf(expPc));
            $display("pop pc=%h instr=%h", o_pc, o_instr);
            expPc += 32'd4;
        end

        // Fill again, then assert reset mid-cycle.
        repeat (10) autoCycle(1'b1);
        check("full_valid", {31'b0, o_instr_valid}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'b0, o_instr_valid}, 32'd0);
        check("arst_req", {31'b0, o_req}, 32'd0);
        check("arst_pc", o_pc, 32'd0);
        $display("async reset: valid=%0b req=%0b", o_instr_valid, o_req);
        doReset(32'h500);
        autoCycle(1'b0);
        check("reboot_c0_req", {31'b0, o_req}, 32'd0);
        autoCycle(1'b0);
        check("reboot_req", {31'b0, o_req}, 32'd1);
        check("reboot_addr", o_addr, 32'h500);
        autoCycle(1'b0);
        autoCycle(1'b0);
        check("reboot_pc", o_pc, 32'h500);
        check("reboot_instr", o_instr, instrOf(32'h500));
        $display("reboot: pc=%h instr=%h", o_pc, o_instr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_fetch_buffer.md
# riscv_fetch_buffer

Instruction prefetch buffer between the pipeline's IF stage and instruction memory. Issues sequential word fetches ahead of the consumer, holds returned instructions with their PCs in a small FIFO, and flushes cleanly on a taken jump or branch. Decouples memory latency from the FD pipeline register so IF sees a ready instruction every cycle on straight-line code.

## Interface
- DEPTH, 4: FIFO entries; also the cap on outstanding plus buffered fetches (power of two, at least 2).
- ADDR_W, 32: address width.
- DATA_W, 32: instruction width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_boot_addr  in  ADDR_W  first fetch address after reset; sampled in BOOT.
- i_redirect  in  1  taken jump/branch; flush and refetch.
- i_redirect_pc  in  ADDR_W  new fetch address; bits [1:0] ignored.
- i_stall  in  1  consumer cannot accept this cycle.
- o_instr_valid  out  1  head entry valid.
- o_instr  out  DATA_W  head instruction.
- o_pc  out  ADDR_W  PC of head instruction.
- o_req  out  1  memory fetch request.
- o_addr  out  ADDR_W  fetch address, word aligned.
- i_gnt  in  1  request accepted this cycle.
- i_rvalid  in  1  response data valid; responses are in order, at least 1 cycle after gnt.
- i_rdata  in  DATA_W  response instruction.

## Operation
- FSM states: BOOT, RUN. Reset enters BOOT. BOOT lasts one cycle, loads fetch_pc <= {i_boot_addr[ADDR_W-1:2],2'b00}, then moves to RUN. RUN persists until reset.
- Issue rule (RUN): o_req=1 when fifo_count + outstanding < DEPTH, or when a request is already pending. Once raised, o_req and o_addr stay stable until i_gnt. On gnt: outstanding++ and fetch_pc += 4, wrapping 0xFFFF_FFFC -> 0.
- A pending ungranted request is never withdrawn, including across a redirect.
- Response: on i_rvalid, outstanding--. If discard_cnt > 0, discard_cnt-- and drop the data. Otherwise push {resp_pc, i_rdata}; resp_pc tracks the issue order and advances by 4 per kept response.
- Pop: when o_instr_valid && !i_stall.
- Redirect:
  - FIFO flushed.
  - discard_cnt <= outstanding after this cycle's gnt/rvalid accounting, plus 1 if a request is still pending ungranted.
  - fetch_pc and resp_pc <= aligned i_redirect_pc.
  - If a request is still pending, the first new-stream request follows after its gnt.
- Simultaneous events:
  - Redirect with pop: pop ignored.
  - Redirect with rvalid: response discarded and not counted in the new discard_cnt.
  - Redirect with gnt: the granted old-address request is included in discard_cnt.
  - Push and pop in the same cycle are both allowed when the FIFO is full.
- The credit rule guarantees the FIFO never overflows. Responses are never stalled.

## Timing
- Reset values: o_req=0, o_addr=0, o_instr_valid=0, o_instr=0, o_pc=0. Internal counters are 0 and state is BOOT.
- Reset release at edge 0: BOOT in cycle 0, first o_req in cycle 1 with o_addr=boot.
- Latency: i_rvalid in cycle N gives o_instr_valid in cycle N+1 (registered FIFO, no bypass).
- Redirect in cycle N: o_instr_valid=0 from N+1. o_req with the new address at N+1 if nothing is pending.
- Sustained throughput: 1 instruction per cycle when gnt is always high and rvalid follows 1 cycle later.
- Reset asserted mid-operation clears everything immediately. The memory side must be reset by the same rst_n so no stale responses return.

## Structure
- Package riscv_fetch_pkg holds:
  - the fetch_state_e enum {BOOT, RUN};
  - the fetch_entry_t struct {pc, instr};
  - the default DEPTH constant.
- Sub-module riscv_fetch_fifo: synchronous FIFO of fetch_entry_t with push, pop and flush, plus full, empty and count outputs. Flush has priority over push and pop.
- The top holds the FSM, the fetch_pc, resp_pc, outstanding and discard_cnt counters, and the issue logic.

## Test plan
- Boot: i_boot_addr=0x100, gnt=1, 1-cycle rvalid, i_stall=0 -> o_pc sequence 0x100, 0x104, 0x108..., one per cycle after a 3-cycle startup.
- Backpressure: i_stall=1 for 10 cycles -> fifo fills to 4, outstanding 0, o_req drops. Release -> 4 pops then steady flow with no lost or duplicated PC.
- Redirect with in-flight fetches: 2 outstanding, redirect to 0x2002 -> both old responses dropped, next o_pc=0x2000.
- Redirect while o_req pending and gnt low for 3 cycles -> o_addr unchanged until gnt, its response discarded, next request at the redirect address.
- Corner cases:
  - Fetch at 0xFFFF_FFFC -> next o_addr is 0x0000_0000.
  - Redirect and rvalid in the same cycle -> no stale instruction emitted.
- Reset asserted with a full FIFO -> o_instr_valid and o_req drop immediately. After release, fetching restarts at i_boot_addr.
